// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline stall/flush controller: memory wait, halt, branch flush and data-hazard bubbles.
// Build option: HAZARD_FORWARD_EN limits data hazards to load-use (forwarding covers the rest).
module pipeline_hazard_ctrl (
   input  logic        CLK,
   input  logic        RST,
   input  logic        ihit,
   input  logic        dhit,
   input  logic [4:0]  Rs_IF_ID,
   input  logic [4:0]  Rt_IF_ID,
   input  logic        uses_rt_IF_ID,
   input  logic        WEN_ID_EX,
   input  logic        dREN_ID_EX,
   input  logic [4:0]  wsel_ID_EX,
   input  logic        WEN_EX_MEM,
   input  logic        dREN_EX_MEM,
   input  logic        dWEN_EX_MEM,
   input  logic [4:0]  wsel_EX_MEM,
   input  logic        branch_taken_EX,
   input  logic        halt_EX_MEM,
   output logic        pc_en,
   output logic        enable_IF_ID,
   output logic        flush_IF_ID,
   output logic        enable_ID_EX,
   output logic        flush_ID_EX,
   output logic        enable_EX_MEM,
   output logic        flush_EX_MEM,
   output logic        enable_MEM_WB,
   output logic        halted,
   output logic [15:0] stall_cycles
);

   typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

   state_t      state_q, state_d;
   logic        halted_q;
   logic [15:0] stall_q, stall_d;

   logic mem_stall, run_cyc;
   logic rs_ex, rt_ex, load_use, data_haz;

   assign mem_stall = (dREN_EX_MEM | dWEN_EX_MEM) & ~dhit;

   assign rs_ex    = (wsel_ID_EX == Rs_IF_ID);
   assign rt_ex    = uses_rt_IF_ID & (wsel_ID_EX == Rt_IF_ID);
   assign load_use = dREN_ID_EX & WEN_ID_EX & (wsel_ID_EX != 5'd0) & (rs_ex | rt_ex);

`ifdef HAZARD_FORWARD_EN
   assign data_haz = load_use;
`else
   logic rs_mem, rt_mem, raw_ex, raw_mem;
   assign rs_mem   = (wsel_EX_MEM == Rs_IF_ID);
   assign rt_mem   = uses_rt_IF_ID & (wsel_EX_MEM == Rt_IF_ID);
   assign raw_ex   = WEN_ID_EX & (wsel_ID_EX != 5'd0) & (rs_ex | rt_ex);
   assign raw_mem  = WEN_EX_MEM & (wsel_EX_MEM != 5'd0) & (rs_mem | rt_mem);
   assign data_haz = load_use | raw_ex | raw_mem;
`endif

   // A MEM_WAIT cycle that sees dhit behaves exactly like a RUN cycle.
   assign run_cyc = ~RST & ((state_q == RUN) | ((state_q == MEM_WAIT) & dhit));

   always_comb begin
      state_d       = state_q;
      pc_en         = 1'b0;
      enable_IF_ID  = 1'b0;
      flush_IF_ID   = 1'b0;
      enable_ID_EX  = 1'b0;
      flush_ID_EX   = 1'b0;
      enable_EX_MEM = 1'b0;
      flush_EX_MEM  = 1'b0;
      enable_MEM_WB = 1'b0;
      if (RST) begin
         state_d = RUN;
      end else if (run_cyc) begin
         state_d = RUN;
         if (mem_stall) begin
            state_d = MEM_WAIT;
         end else if (halt_EX_MEM) begin
            state_d       = HALT;
            enable_MEM_WB = 1'b1;
            flush_EX_MEM  = 1'b1;
         end else if (branch_taken_EX) begin
            pc_en         = 1'b1;
            enable_IF_ID  = 1'b1;
            flush_IF_ID   = 1'b1;
            enable_ID_EX  = 1'b1;
            flush_ID_EX   = 1'b1;
            enable_EX_MEM = 1'b1;
            enable_MEM_WB = 1'b1;
         end else if (data_haz | ~ihit) begin
            // Hold PC and IF/ID, push a bubble into ID/EX, let the rest drain.
            enable_ID_EX  = 1'b1;
            flush_ID_EX   = 1'b1;
            enable_EX_MEM = 1'b1;
            enable_MEM_WB = 1'b1;
         end else begin
            pc_en         = 1'b1;
            enable_IF_ID  = 1'b1;
            enable_ID_EX  = 1'b1;
            enable_EX_MEM = 1'b1;
            enable_MEM_WB = 1'b1;
         end
      end
   end

   always_comb begin
      stall_d = stall_q;
      if ((state_q != HALT) && !pc_en && (stall_q != 16'hFFFF))
         stall_d = stall_q + 16'd1;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= RUN;
         halted_q <= 1'b0;
         stall_q  <= 16'd0;
      end else begin
         state_q  <= state_d;
         halted_q <= (state_d == HALT);
         stall_q  <= stall_d;
      end
   end

   assign halted       = halted_q;
   assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with a rule-level reference model checked every cycle.
module tb_pipeline_hazard_ctrl;

   logic        CLK = 1'b0;
   logic        RST;
   logic        ihit, dhit;
   logic [4:0]  Rs_IF_ID, Rt_IF_ID;
   logic        uses_rt_IF_ID;
   logic        WEN_ID_EX, dREN_ID_EX;
   logic [4:0]  wsel_ID_EX;
   logic        WEN_EX_MEM, dREN_EX_MEM, dWEN_EX_MEM;
   logic [4:0]  wsel_EX_MEM;
   logic        branch_taken_EX, halt_EX_MEM;
   logic        pc_en, enable_IF_ID, flush_IF_ID, enable_ID_EX, flush_ID_EX;
   logic        enable_EX_MEM, flush_EX_MEM, enable_MEM_WB, halted;
   logic [15:0] stall_cycles;

   pipeline_hazard_ctrl dut (
      .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
      .Rs_IF_ID(Rs_IF_ID), .Rt_IF_ID(Rt_IF_ID), .uses_rt_IF_ID(uses_rt_IF_ID),
      .WEN_ID_EX(WEN_ID_EX), .dREN_ID_EX(dREN_ID_EX), .wsel_ID_EX(wsel_ID_EX),
      .WEN_EX_MEM(WEN_EX_MEM), .dREN_EX_MEM(dREN_EX_MEM), .dWEN_EX_MEM(dWEN_EX_MEM),
      .wsel_EX_MEM(wsel_EX_MEM), .branch_taken_EX(branch_taken_EX), .halt_EX_MEM(halt_EX_MEM),
      .pc_en(pc_en), .enable_IF_ID(enable_IF_ID), .flush_IF_ID(flush_IF_ID),
      .enable_ID_EX(enable_ID_EX), .flush_ID_EX(flush_ID_EX), .enable_EX_MEM(enable_EX_MEM),
      .flush_EX_MEM(flush_EX_MEM), .enable_MEM_WB(enable_MEM_WB),
      .halted(halted), .stall_cycles(stall_cycles)
   );

   always #5 CLK = ~CLK;

   // Control word {pc_en, en_IF_ID, fl_IF_ID, en_ID_EX, fl_ID_EX, en_EX_MEM, fl_EX_MEM, en_MEM_WB}
   localparam logic [7:0] C_OFF    = 8'h00;
   localparam logic [7:0] C_NORMAL = 8'hD5;
   localparam logic [7:0] C_BRANCH = 8'hFD;
   localparam logic [7:0] C_BUBBLE = 8'h1D;
   localparam logic [7:0] C_HALT   = 8'h03;

   int pass_cnt = 0;
   int total_cnt = 0;

   // Reference model state
   bit m_armed = 0;
   bit m_wait = 0;
   bit m_halted = 0;
   int m_stalls = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      else pass_cnt++;
   endtask

   function automatic bit m_hazard();
      bit src_ex  = (wsel_ID_EX == Rs_IF_ID) || (uses_rt_IF_ID && wsel_ID_EX == Rt_IF_ID);
      bit src_mem = (wsel_EX_MEM == Rs_IF_ID) || (uses_rt_IF_ID && wsel_EX_MEM == Rt_IF_ID);
      bit ex_live  = WEN_ID_EX && wsel_ID_EX != 0 && src_ex;
      bit mem_live = WEN_EX_MEM && wsel_EX_MEM != 0 && src_mem;
`ifdef HAZARD_FORWARD_EN
      return ex_live && dREN_ID_EX;
`else
      return ex_live || mem_live;
`endif
   endfunction

   function automatic logic [7:0] m_ctl();
      if (RST || m_halted) return C_OFF;
      if (m_wait && !dhit) return C_OFF;
      if ((dREN_EX_MEM || dWEN_EX_MEM) && !dhit) return C_OFF;
      if (halt_EX_MEM) return C_HALT;
      if (branch_taken_EX) return C_BRANCH;
      if (m_hazard() || !ihit) return C_BUBBLE;
      return C_NORMAL;
   endfunction

   function automatic logic [7:0] dut_ctl();
      return {pc_en, enable_IF_ID, flush_IF_ID, enable_ID_EX, flush_ID_EX,
              enable_EX_MEM, flush_EX_MEM, enable_MEM_WB};
   endfunction

   always @(posedge CLK) begin
      logic [7:0] c;
      c = m_ctl();
      if (RST) begin
         m_armed = 1; m_wait = 0; m_halted = 0; m_stalls = 0;
      end else if (m_armed && !m_halted) begin
         if (!c[7]) m_stalls = (m_stalls + 1 > 65535) ? 65535 : m_stalls + 1;
         m_halted = (c == C_HALT);
         m_wait   = (c == C_OFF);
      end
   end

   always @(negedge CLK) begin
      if (m_armed) begin
         chk("model_ctl", {24'd0, dut_ctl()}, {24'd0, m_ctl()});
         chk("model_halted", {31'd0, halted}, {31'd0, m_halted});
         chk("model_stalls", {16'd0, stall_cycles}, m_stalls);
      end
   end

   task automatic idle();
      ihit = 1; dhit = 1; Rs_IF_ID = 0; Rt_IF_ID = 0; uses_rt_IF_ID = 0;
      WEN_ID_EX = 0; dREN_ID_EX = 0; wsel_ID_EX = 0;
      WEN_EX_MEM = 0; dREN_EX_MEM = 0; dWEN_EX_MEM = 0; wsel_EX_MEM = 0;
      branch_taken_EX = 0; halt_EX_MEM = 0;
   endtask

   task automatic step();
      @(posedge CLK); #1;
   endtask

   task automatic reset_pulse();
      RST = 1; step(); RST = 0;
   endtask

   initial begin
      int base;
      idle(); RST = 1;
      step(); step();
      @(negedge CLK);
      chk("rst_ctl", {24'd0, dut_ctl()}, C_OFF);
      chk("rst_halted", {31'd0, halted}, 0);
      chk("rst_stalls", {16'd0, stall_cycles}, 0);
      step(); RST = 0;
      @(negedge CLK); chk("run_normal", {24'd0, dut_ctl()}, C_NORMAL);

      // load-use bubble
      step(); base = stall_cycles;
      dREN_ID_EX = 1; WEN_ID_EX = 1; wsel_ID_EX = 5; Rs_IF_ID = 5;
      @(negedge CLK); chk("loaduse_ctl", {24'd0, dut_ctl()}, C_BUBBLE);
      step(); idle();
      @(negedge CLK); chk("loaduse_release", {24'd0, dut_ctl()}, C_NORMAL);
      chk("loaduse_stalls", {16'd0, stall_cycles}, base + 1);

      // load to r0 is never a hazard
      step(); dREN_ID_EX = 1; WEN_ID_EX = 1; wsel_ID_EX = 0; Rs_IF_ID = 0;
      @(negedge CLK); chk("r0_nohaz", {24'd0, dut_ctl()}, C_NORMAL);

      // ihit miss
      step(); idle(); ihit = 0;
      @(negedge CLK); chk("imiss_ctl", {24'd0, dut_ctl()}, C_BUBBLE);

      // memory wait: 3 miss cycles, middle one with request dropped to prove MEM_WAIT holds
      step(); idle(); reset_pulse();
      dREN_EX_MEM = 1; dhit = 0;
      @(negedge CLK); chk("mw_c1", {24'd0, dut_ctl()}, C_OFF);
      step(); dREN_EX_MEM = 0;
      @(negedge CLK); chk("mw_c2_hold", {24'd0, dut_ctl()}, C_OFF);
      step(); dREN_EX_MEM = 1;
      @(negedge CLK); chk("mw_c3", {24'd0, dut_ctl()}, C_OFF);
      step(); dhit = 1;
      @(negedge CLK); chk("mw_hit", {24'd0, dut_ctl()}, C_NORMAL);
      chk("mw_stalls", {16'd0, stall_cycles}, 3);

      // branch overrides load-use
      step(); idle(); base = stall_cycles;
      branch_taken_EX = 1; dREN_ID_EX = 1; WEN_ID_EX = 1; wsel_ID_EX = 9; Rs_IF_ID = 9;
      @(negedge CLK); chk("br_haz_ctl", {24'd0, dut_ctl()}, C_BRANCH);
      step(); idle();
      @(negedge CLK); chk("br_haz_nostall", {16'd0, stall_cycles}, base);

      // EX/MEM producer matching Rt
      step(); WEN_EX_MEM = 1; wsel_EX_MEM = 7; Rt_IF_ID = 7; uses_rt_IF_ID = 1;
`ifdef HAZARD_FORWARD_EN
      @(negedge CLK); chk("cfg_exmem_raw", {24'd0, dut_ctl()}, C_NORMAL);
`else
      @(negedge CLK); chk("cfg_exmem_raw", {24'd0, dut_ctl()}, C_BUBBLE);
`endif
      step(); uses_rt_IF_ID = 0;
      @(negedge CLK); chk("rt_unused", {24'd0, dut_ctl()}, C_NORMAL);

      // store miss beats halt, halt completes on the dhit cycle
      step(); idle(); dWEN_EX_MEM = 1; dhit = 0; halt_EX_MEM = 1;
      @(negedge CLK); chk("stall_over_halt", {24'd0, dut_ctl()}, C_OFF);
      step(); dhit = 1;
      @(negedge CLK); chk("halt_ctl", {24'd0, dut_ctl()}, C_HALT);
      step(); idle();
      @(negedge CLK); chk("halted_set", {31'd0, halted}, 1);
      chk("halted_ctl", {24'd0, dut_ctl()}, C_OFF);
      base = stall_cycles;
      repeat (10) step();
      @(negedge CLK); chk("halted_hold", {31'd0, halted}, 1);
      chk("halted_nocount", {16'd0, stall_cycles}, base);
      step(); RST = 1;
      @(negedge CLK); chk("rst_force_off", {24'd0, dut_ctl()}, C_OFF);
      step(); RST = 0;
      @(negedge CLK); chk("halt_cleared", {31'd0, halted}, 0);
      chk("halt_to_run", {24'd0, dut_ctl()}, C_NORMAL);

      // reset in the middle of a memory wait
      step(); dREN_EX_MEM = 1; dhit = 0;
      step(); step(); idle(); dhit = 0; RST = 1;
      step(); RST = 0;
      @(negedge CLK); chk("mw_rst_run", {24'd0, dut_ctl()}, C_NORMAL);
      chk("mw_rst_stalls", {16'd0, stall_cycles}, 0);

      // saturation
      step(); idle(); ihit = 0;
      repeat (70000) step();
      @(negedge CLK); chk("sat_value", {16'd0, stall_cycles}, 32'hFFFF);
      step(); step();
      @(negedge CLK); chk("sat_nowrap", {16'd0, stall_cycles}, 32'hFFFF);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
